// File: rtl/avalon_mm_pkg.sv
// Shared definitions for the Avalon-MM register file: the FSM state encoding,
// the response codes and the default ID register value.
package avalon_mm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h0A5A_0001;

endpackage

// File: rtl/avalon_mm_wait_ctr.sv
// Wait-state down-counter: load sets the count, clear zeroes it, and done is
// high while the count sits at zero.
module avalon_mm_wait_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       clear,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if (clear) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign done = (cnt == 4'd0);

endmodule

// File: rtl/avalon_mm_regfile.sv
// Avalon-MM slave register file with programmable wait states and a read-only
// ID register at index 0. Defining AVALON_MM_REGFILE_RESP_EN adds response[1:0].
module avalon_mm_regfile
  import avalon_mm_pkg::*;
#(
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 32,
  parameter int              NUM_REGS    = 8,
  parameter int              WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] ID_VALUE  = DATA_W'(ID_VALUE_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   address,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W/8-1:0] byteenable,
  output logic [DATA_W-1:0]   readdata,
  output logic                waitrequest
`ifdef AVALON_MM_REGFILE_RESP_EN
  ,
  output logic [1:0]          response
`endif
);

  localparam int BE_W      = DATA_W / 8;
  localparam int ADDR_LSB  = $clog2(BE_W);
  localparam int IDX_W     = $clog2(NUM_REGS);
  localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  state_t              state, state_nxt;
  logic                req;
  logic                ctr_load, ctr_clear, ctr_done;
  logic [IDX_W-1:0]    live_idx, cur_idx, idx_q;
  logic                cur_wr, wr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   regs [1:NUM_REGS-1];
  logic                unused_addr;

  assign req         = chipselect & (read | write);
  assign live_idx    = address[ADDR_LSB +: IDX_W];
  assign unused_addr = ^address;
  assign waitrequest = req & (state != ACK);

  // When entering ACK straight from IDLE the sampled copies are not yet loaded.
  assign cur_idx = (state == IDLE) ? live_idx : idx_q;
  assign cur_wr  = (state == IDLE) ? write : wr_q;

  function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
    idx_valid = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) idx_valid = 1'b1;
    end
  endfunction

  function automatic logic [DATA_W-1:0] rd_word(input logic [IDX_W-1:0] idx);
    rd_word = '0;
    if (idx == '0) rd_word = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) rd_word = regs[i];
    end
  endfunction

  avalon_mm_wait_ctr u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (4'(WAIT_LOAD)),
    .clear    (ctr_clear),
    .done     (ctr_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ctr_load  = 1'b0;
    ctr_clear = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            ctr_load  = 1'b1;
          end else begin
            state_nxt = ACK;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
          ctr_clear = 1'b1;
        end else if (ctr_done) begin
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sample the command on leaving IDLE, load readdata on entering ACK and
  // commit writes on the edge that ends ACK.
  always_ff @(posedge clk) begin
    if (!reset) begin
      readdata <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (state == IDLE && state_nxt != IDLE) begin
        idx_q   <= live_idx;
        wdata_q <= writedata;
        be_q    <= byteenable;
        wr_q    <= write;
      end
      if (state_nxt == ACK && state != ACK && !cur_wr) begin
        readdata <= rd_word(cur_idx);
      end
      if (state == ACK && wr_q) begin
        for (int i = 1; i < NUM_REGS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            for (int b = 0; b < BE_W; b++) begin
              if (be_q[b]) regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
            end
          end
        end
      end
    end
  end

`ifdef AVALON_MM_REGFILE_RESP_EN
  assign response = (state == ACK && (!idx_valid(idx_q) || (wr_q && idx_q == '0)))
                    ? SLVERR : OKAY;
`endif

endmodule

// File: tb/tb_avalon_mm_regfile.sv
// Scoreboard bench for avalon_mm_regfile: three instances with 0, 3 and 5 wait
// states; a monitor pops expected completions from a queue and compares them.
module tb_avalon_mm_regfile;

  localparam int N = 3;
  localparam logic [31:0] ID = 32'h0A5A_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address [N];
  logic [31:0] wdata   [N];
  logic [3:0]  be      [N];
  logic [31:0] rdata   [N];
  logic [N-1:0] cs, rd, wr, wreq;
`ifdef AVALON_MM_REGFILE_RESP_EN
  logic [1:0]  resp    [N];
`endif

  always #5 clk = ~clk;

  avalon_mm_regfile #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .address(address[0]), .chipselect(cs[0]),
    .read(rd[0]), .write(wr[0]), .writedata(wdata[0]), .byteenable(be[0]),
    .readdata(rdata[0]), .waitrequest(wreq[0])
`ifdef AVALON_MM_REGFILE_RESP_EN
    , .response(resp[0])
`endif
  );

  avalon_mm_regfile #(.WAIT_CYCLES(3), .NUM_REGS(6)) u1 (
    .clk(clk), .reset(reset), .address(address[1]), .chipselect(cs[1]),
    .read(rd[1]), .write(wr[1]), .writedata(wdata[1]), .byteenable(be[1]),
    .readdata(rdata[1]), .waitrequest(wreq[1])
`ifdef AVALON_MM_REGFILE_RESP_EN
    , .response(resp[1])
`endif
  );

  avalon_mm_regfile #(.WAIT_CYCLES(5)) u2 (
    .clk(clk), .reset(reset), .address(address[2]), .chipselect(cs[2]),
    .read(rd[2]), .write(wr[2]), .writedata(wdata[2]), .byteenable(be[2]),
    .readdata(rdata[2]), .waitrequest(wreq[2])
`ifdef AVALON_MM_REGFILE_RESP_EN
    , .response(resp[2])
`endif
  );

  typedef struct {
    int          d;
    bit          is_rd;
    logic [31:0] data;
    int          waits;
    logic [1:0]  resp;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   wcnt [N];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: count stalled cycles, and on each completed access pop and compare.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < N; d++) begin
      if (reset && cs[d] && (rd[d] || wr[d])) begin
        if (wreq[d]) begin
          wcnt[d]++;
        end else begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion dut%0d addr %h", d, address[d]);
          end else begin
            e = sbq.pop_front();
            check32($sformatf("dut_id dut%0d", d), d, e.d);
            check32($sformatf("wait_cycles dut%0d addr %h", d, address[d]), wcnt[d], e.waits);
            if (e.is_rd)
              check32($sformatf("readdata dut%0d addr %h", d, address[d]), rdata[d], e.data);
`ifdef AVALON_MM_REGFILE_RESP_EN
            check32($sformatf("response dut%0d addr %h", d, address[d]), 32'(resp[d]), 32'(e.resp));
`endif
          end
          wcnt[d] = 0;
        end
      end else begin
        wcnt[d] = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that ends ACK.
  task automatic access(input int d, input logic [31:0] a, input bit r, input bit w,
                        input logic [31:0] wd, input logic [3:0] b,
                        input logic [31:0] exp_rd, input int exp_w, input logic [1:0] exp_resp);
    exp_t e;
    int   guard;
    bit   done;
    e.d = d; e.is_rd = r && !w; e.data = exp_rd; e.waits = exp_w; e.resp = exp_resp;
    sbq.push_back(e);
    address[d] = a; rd[d] = r; wr[d] = w; wdata[d] = wd; be[d] = b; cs[d] = 1'b1;
    guard = 0;
    done  = 1'b0;
    while (!done && guard < 64) begin
      @(negedge clk);
      done = !wreq[d];
      @(posedge clk);
      #1;
      guard++;
    end
    cs[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d addr %h", d, a);
    end
  endtask

  task automatic wr_acc(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, input int w, input logic [1:0] rs);
    access(d, a, 1'b0, 1'b1, wd, b, 32'h0, w, rs);
  endtask

  task automatic rd_acc(input int d, input logic [31:0] a, input logic [31:0] exp,
                        input int w, input logic [1:0] rs);
    access(d, a, 1'b1, 1'b0, 32'h0, 4'h0, exp, w, rs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cs = '0; rd = '0; wr = '0;
    for (int d = 0; d < N; d++) begin
      address[d] = '0; wdata[d] = '0; be[d] = '0; wcnt[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check32($sformatf("reset_readdata dut%0d", d), rdata[d], 32'h0);
      check32($sformatf("reset_waitrequest dut%0d", d), 32'(wreq[d]), 32'h0);
    end
    @(posedge clk);
    #1;

    // Zero wait states: full write, byte-lane merge, ID register, read+write.
    wr_acc(0, 32'h4, 32'hDEADBEEF, 4'hF, 1, 2'b00);
    rd_acc(0, 32'h4, 32'hDEADBEEF, 1, 2'b00);
    wr_acc(0, 32'h8, 32'h11223344, 4'hF, 1, 2'b00);
    wr_acc(0, 32'h8, 32'hAABBCCDD, 4'b0101, 1, 2'b00);
    rd_acc(0, 32'h8, 32'h11BB33DD, 1, 2'b00);
    wr_acc(0, 32'h0, 32'h12345678, 4'hF, 1, 2'b10);
    wr_acc(0, 32'h40, 32'h12345678, 4'hF, 1, 2'b10);
    rd_acc(0, 32'h0, ID, 1, 2'b00);
    access(0, 32'h4, 1'b1, 1'b1, 32'h55555555, 4'hF, 32'h0, 1, 2'b00);
    @(negedge clk);
    check32("readdata_held_after_rdwr", rdata[0], ID);
    @(posedge clk);
    #1;
    rd_acc(0, 32'h25, 32'h55555555, 1, 2'b00);

    // Three wait states, six registers: index 6 is out of range.
    rd_acc(1, 32'h0, ID, 4, 2'b00);
    wr_acc(1, 32'h18, 32'h12345678, 4'hF, 4, 2'b10);
    rd_acc(1, 32'h18, 32'h0, 4, 2'b10);
    wr_acc(1, 32'h14, 32'hCAFEF00D, 4'hF, 4, 2'b00);
    rd_acc(1, 32'h14, 32'hCAFEF00D, 4, 2'b00);

    // Five wait states: withdrawn write, then reset in the middle of a write.
    wr_acc(2, 32'hC, 32'h01020304, 4'hF, 6, 2'b00);
    rd_acc(2, 32'hC, 32'h01020304, 6, 2'b00);
    address[2] = 32'hC; wdata[2] = 32'hFFFFFFFF; be[2] = 4'hF; wr[2] = 1'b1; cs[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1 cs[2] = 1'b0; wr[2] = 1'b0;
    @(posedge clk);
    #1;
    rd_acc(2, 32'hC, 32'h01020304, 6, 2'b00);
    wr_acc(2, 32'h4, 32'h00000077, 4'hF, 6, 2'b00);
    address[2] = 32'h4; wdata[2] = 32'h0BADF00D; be[2] = 4'hF; wr[2] = 1'b1; cs[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; cs[2] = 1'b0; wr[2] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check32("readdata_after_midreset", rdata[2], 32'h0);
    check32("waitrequest_after_midreset", 32'(wreq[2]), 32'h0);
    @(posedge clk);
    #1;
    rd_acc(2, 32'h4, 32'h0, 6, 2'b00);
    wr_acc(2, 32'h4, 32'h600DCAFE, 4'hF, 6, 2'b00);
    rd_acc(2, 32'h4, 32'h600DCAFE, 6, 2'b00);

    repeat (3) @(posedge clk);
    check32("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
